// File: rtl/if_fetch_ctrl_if.sv
// Fetch-side handshake bundle between the IF fetch sequencer, IF, Q_IFID and the
// branch-resolving stage. The sequencer is the master.
interface if_fetch_ctrl_if;
  logic        tQ_IFID_full;
  logic        imem_ready;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        FREEZE;
  logic        no_new_fetch;
  logic        taken_branch1;
  logic [31:0] nextInstruction_address;
  logic        fetchNull2;

  modport master (
    input  tQ_IFID_full, imem_ready, branch_valid, branch_target,
    output FREEZE, no_new_fetch, taken_branch1, nextInstruction_address, fetchNull2
  );

  modport slave (
    output tQ_IFID_full, imem_ready, branch_valid, branch_target,
    input  FREEZE, no_new_fetch, taken_branch1, nextInstruction_address, fetchNull2
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: start-up warm-up, back-pressure stall, taken-branch redirect
// and wrong-path squash. Define IFCTRL_PERF_CNT_EN to add saturating perf counters.
module if_fetch_ctrl #(
  parameter int START_DELAY  = 2,
  parameter int SQUASH_SLOTS = 1
`ifdef IFCTRL_PERF_CNT_EN
  , parameter int CNT_W      = 32
`endif
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           start,
  input  logic           halt_req,
  if_fetch_ctrl_if.master bus,
  output logic           halted,
  output logic [2:0]     state_o
`ifdef IFCTRL_PERF_CNT_EN
  , output logic [CNT_W-1:0] fetch_cnt
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] squash_cnt
`endif
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WARM   = 3'd1;
  localparam logic [2:0] RUN    = 3'd2;
  localparam logic [2:0] STALL  = 3'd3;
  localparam logic [2:0] REDIR  = 3'd4;
  localparam logic [2:0] SQUASH = 3'd5;
  localparam logic [2:0] HALT   = 3'd6;

  localparam int DW = (START_DELAY  > 2) ? $clog2(START_DELAY)    : 1;
  localparam int SW = (SQUASH_SLOTS > 1) ? $clog2(SQUASH_SLOTS+1) : 1;
  localparam logic [DW-1:0] WARM_INIT = DW'((START_DELAY > 0) ? START_DELAY - 1 : 0);
  localparam logic [SW-1:0] SQ_INIT   = SW'(SQUASH_SLOTS);

  logic [2:0]    state_q, state_d;
  logic          pend_q, pend_d;
  logic [31:0]   tgt_q, tgt_d;
  logic [DW-1:0] wcnt_q, wcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic          tb1_q, tb1_d;
  logic          fn2_q, fn2_d;
  logic          halted_q, halted_d;

  logic active, freeze, accept, bp, capture;

  assign active = (state_q == RUN) || (state_q == REDIR) || (state_q == SQUASH);
  assign bp     = bus.tQ_IFID_full || !bus.imem_ready;
  assign freeze = !active || bp;
  assign accept = !freeze && active;

  assign bus.FREEZE                  = freeze;
  assign bus.no_new_fetch            = !active;
  assign bus.taken_branch1           = tb1_q;
  assign bus.nextInstruction_address = tgt_q;
  assign bus.fetchNull2              = fn2_q;
  assign halted                      = halted_q;
  assign state_o                     = state_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    tgt_d   = tgt_q;
    wcnt_d  = wcnt_q;
    scnt_d  = scnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          if (START_DELAY == 0) begin
            state_d = pend_q ? REDIR : RUN;
          end else begin
            state_d = WARM;
            wcnt_d  = WARM_INIT;
          end
        end
      end
      WARM: begin
        if (wcnt_q == '0) state_d = pend_q ? REDIR : RUN;
        else              wcnt_d  = wcnt_q - DW'(1);
      end
      RUN: begin
        if (bus.branch_valid) begin
          capture = 1'b1;
          state_d = REDIR;
        end else if (bp) begin
          state_d = STALL;
        end
      end
      STALL: begin
        // first captured target wins until the redirect is issued
        if (bus.branch_valid && !pend_q) capture = 1'b1;
        if (!bp) state_d = (pend_q || capture) ? REDIR : RUN;
      end
      REDIR: begin
        if (accept) begin
          pend_d = 1'b0;
          if (SQUASH_SLOTS > 0) begin
            state_d = SQUASH;
            scnt_d  = SQ_INIT;
          end else begin
            state_d = RUN;
          end
        end
      end
      SQUASH: begin
        if (bus.branch_valid) begin
          capture = 1'b1;
          state_d = REDIR;
        end else if (accept) begin
          scnt_d = scnt_q - SW'(1);
          if (scnt_q == SW'(1)) state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      tgt_d  = bus.branch_target;
      pend_d = 1'b1;
    end
    // halt overrides every transition but keeps any captured redirect
    if (halt_req && state_q != IDLE) state_d = HALT;
    tb1_d    = (state_d == REDIR);
    fn2_d    = (state_d == SQUASH);
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= IDLE;
      pend_q   <= 1'b0;
      tgt_q    <= '0;
      wcnt_q   <= '0;
      scnt_q   <= '0;
      tb1_q    <= 1'b0;
      fn2_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      tgt_q    <= tgt_d;
      wcnt_q   <= wcnt_d;
      scnt_q   <= scnt_d;
      tb1_q    <= tb1_d;
      fn2_q    <= fn2_d;
      halted_q <= halted_d;
    end
  end

`ifdef IFCTRL_PERF_CNT_EN
  logic [CNT_W-1:0] fc_q, fc_d, sc_q, sc_d, qc_q, qc_d;

  always_comb begin
    fc_d = fc_q;
    sc_d = sc_q;
    qc_d = qc_q;
    if (accept && ~&fc_q)           fc_d = fc_q + CNT_W'(1);
    if (active && freeze && ~&sc_q) sc_d = sc_q + CNT_W'(1);
    if (accept && fn2_q && ~&qc_q)  qc_d = qc_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      fc_q <= '0;
      sc_q <= '0;
      qc_q <= '0;
    end else begin
      fc_q <= fc_d;
      sc_q <= sc_d;
      qc_q <= qc_d;
    end
  end

  assign fetch_cnt  = fc_q;
  assign stall_cnt  = sc_q;
  assign squash_cnt = qc_q;
`endif
endmodule
